// File: rtl/csr_req_pkg.sv
// Shared types and encodings for the CSR request sequencer and its decoder.
package csr_req_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } csr_state_e;

  // Zicsr funct3 encodings; 000 and 100 are not CSR accesses.
  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b00;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  localparam int unsigned OP_WRITE_BIT = 0;
  localparam int unsigned OP_READ_BIT  = 1;

  function automatic logic [1:0] pack_op(input logic read, input logic write);
    logic [1:0] op;
    op               = '0;
    op[OP_READ_BIT]  = read;
    op[OP_WRITE_BIT] = write;
    return op;
  endfunction

endpackage

// File: rtl/csr_op_decode.sv
// Combinational Zicsr intent decode: which funct3 values are legal and whether the
// access reads and/or writes the CSR.
module csr_op_decode
  import csr_req_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [4:0] rd_idx,
  input  logic [4:0] rs1_idx,
  output logic       illegal,
  output logic       read,
  output logic       write
);

  always_comb begin
    illegal = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    case (funct3)
      // Swap forms always write; the read side effect is skipped when rd is x0.
      CSRRW, CSRRWI: begin
        read  = (rd_idx != 5'd0);
        write = 1'b1;
      end
      // Set/clear forms always read; a zero mask (x0 or zimm 0) suppresses the write.
      CSRRS, CSRRC, CSRRSI, CSRRCI: begin
        read  = 1'b1;
        write = (rs1_idx != 5'd0);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/csr_req_ctrl.sv
// Non-pipelined CSR access sequencer: takes one CSR instruction from issue, runs a single
// bus transaction with a response timeout and hands the result to writeback.
module csr_req_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned REG_WIDTH   = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [4:0]            req_rd_idx,
  input  logic [4:0]            req_rs1_idx,
  input  logic [REG_WIDTH-1:0]  req_rs1_val,
  input  logic [ADDR_WIDTH-1:0] req_csr_addr,
  input  logic                  flush,
  output logic [1:0]            csr_op,
  output logic [2:0]            csr_funct3,
  output logic [4:0]            csr_imm,
  output logic [REG_WIDTH-1:0]  rs1_val,
  output logic [ADDR_WIDTH-1:0] csr_addr,
  output logic                  csr_valid,
  output logic                  csr_rrsp,
  input  logic [ADDR_WIDTH-1:0] csr_rdata,
  input  logic                  csr_rvalid,
  input  logic [2:0]            csr_reg_rsp,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [4:0]            wb_rd_idx,
  output logic                  wb_rd_wen,
  output logic [REG_WIDTH-1:0]  wb_data,
  output logic                  wb_excp,
  output logic [1:0]            wb_cause
);
  import csr_req_pkg::*;

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);

  csr_state_e state_q, state_d;

  logic                  kill_q, kill_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [4:0]            rd_q, rd_d;
  logic                  read_q, read_d;
  logic [1:0]            op_q, op_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [4:0]            imm_q, imm_d;
  logic [REG_WIDTH-1:0]  rs1_q, rs1_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [4:0]            wb_rd_idx_q, wb_rd_idx_d;
  logic                  wb_rd_wen_q, wb_rd_wen_d;
  logic [REG_WIDTH-1:0]  wb_data_q, wb_data_d;
  logic                  wb_excp_q, wb_excp_d;
  logic [1:0]            wb_cause_q, wb_cause_d;

  logic                  dec_illegal, dec_read, dec_write;
  logic                  rsp_take;
  logic                  done;
  logic                  done_excp;
  logic [1:0]            done_cause;
  logic [REG_WIDTH-1:0]  rdata_fit;

  csr_op_decode u_decode (
    .funct3  (req_funct3),
    .rd_idx  (req_rd_idx),
    .rs1_idx (req_rs1_idx),
    .illegal (dec_illegal),
    .read    (dec_read),
    .write   (dec_write)
  );

  if (REG_WIDTH > ADDR_WIDTH) begin : g_rdata_zext
    assign rdata_fit = {{(REG_WIDTH - ADDR_WIDTH){1'b0}}, csr_rdata};
  end else begin : g_rdata_trunc
    assign rdata_fit = csr_rdata[REG_WIDTH-1:0];
  end

  assign req_ready = (state_q == StIdle);
  assign csr_valid = (state_q == StReq);
  assign csr_rrsp  = (state_q == StReq) || (state_q == StWait);
  assign wb_valid  = (state_q == StResp);
  assign rsp_take  = csr_rvalid && csr_rrsp;

  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    read_d      = read_q;
    op_d        = op_q;
    funct3_d    = funct3_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    addr_d      = addr_q;
    wb_rd_idx_d = wb_rd_idx_q;
    wb_rd_wen_d = wb_rd_wen_q;
    wb_data_d   = wb_data_q;
    wb_excp_d   = wb_excp_q;
    wb_cause_d  = wb_cause_q;
    done        = 1'b0;
    done_excp   = 1'b0;
    done_cause  = CAUSE_ILLEGAL;

    case (state_q)
      StIdle: begin
        if (req_valid && !flush) begin
          rd_d   = req_rd_idx;
          read_d = dec_read;
          kill_d = 1'b0;
          cnt_d  = '0;
          if (dec_illegal) begin
            // No bus access: the exception goes straight to writeback.
            state_d     = StResp;
            wb_rd_idx_d = req_rd_idx;
            wb_rd_wen_d = 1'b0;
            wb_data_d   = '0;
            wb_excp_d   = 1'b1;
            wb_cause_d  = CAUSE_ILLEGAL;
          end else begin
            state_d  = StReq;
            op_d     = pack_op(dec_read, dec_write);
            funct3_d = req_funct3;
            imm_d    = req_rs1_idx;
            rs1_d    = req_rs1_val;
            addr_d   = req_csr_addr;
          end
        end
      end

      StReq, StWait: begin
        // A flushed access still completes on the bus since the write may have landed.
        kill_d = kill_q || flush;
        if (rsp_take) begin
          done       = 1'b1;
          done_excp  = csr_reg_rsp[2];
          done_cause = csr_reg_rsp[1:0];
        end else if (state_q == StWait && cnt_q == CntMax) begin
          done       = 1'b1;
          done_excp  = 1'b1;
          done_cause = CAUSE_TIMEOUT;
        end else if (state_q == StWait) begin
          cnt_d = cnt_q + 1'b1;
        end

        if (done) begin
          op_d     = '0;
          funct3_d = '0;
          imm_d    = '0;
          rs1_d    = '0;
          addr_d   = '0;
          if (kill_d) begin
            state_d = StIdle;
          end else begin
            state_d     = StResp;
            wb_rd_idx_d = rd_q;
            wb_rd_wen_d = read_q && (rd_q != 5'd0) && !done_excp;
            wb_data_d   = done_excp ? '0 : rdata_fit;
            wb_excp_d   = done_excp;
            wb_cause_d  = done_cause;
          end
        end else begin
          state_d = StWait;
        end
      end

      StResp: begin
        if (flush || wb_ready) begin
          state_d     = StIdle;
          wb_rd_idx_d = '0;
          wb_rd_wen_d = 1'b0;
          wb_data_d   = '0;
          wb_excp_d   = 1'b0;
          wb_cause_d  = '0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      kill_q      <= 1'b0;
      cnt_q       <= '0;
      rd_q        <= '0;
      read_q      <= 1'b0;
      op_q        <= '0;
      funct3_q    <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      addr_q      <= '0;
      wb_rd_idx_q <= '0;
      wb_rd_wen_q <= 1'b0;
      wb_data_q   <= '0;
      wb_excp_q   <= 1'b0;
      wb_cause_q  <= '0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      read_q      <= read_d;
      op_q        <= op_d;
      funct3_q    <= funct3_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      addr_q      <= addr_d;
      wb_rd_idx_q <= wb_rd_idx_d;
      wb_rd_wen_q <= wb_rd_wen_d;
      wb_data_q   <= wb_data_d;
      wb_excp_q   <= wb_excp_d;
      wb_cause_q  <= wb_cause_d;
    end
  end

  assign csr_op     = op_q;
  assign csr_funct3 = funct3_q;
  assign csr_imm    = imm_q;
  assign rs1_val    = rs1_q;
  assign csr_addr   = addr_q;
  assign wb_rd_idx  = wb_rd_idx_q;
  assign wb_rd_wen  = wb_rd_wen_q;
  assign wb_data    = wb_data_q;
  assign wb_excp    = wb_excp_q;
  assign wb_cause   = wb_cause_q;

endmodule

// File: tb/tb_csr_req_ctrl.sv
// Scoreboard bench for csr_req_ctrl: a latency-programmable bus responder plus a queue of
// expected writeback results checked at each writeback handshake.
module tb_csr_req_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned RW = 32;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_funct3;
  logic [4:0]    req_rd_idx;
  logic [4:0]    req_rs1_idx;
  logic [RW-1:0] req_rs1_val;
  logic [AW-1:0] req_csr_addr;
  logic          flush;
  logic [1:0]    csr_op;
  logic [2:0]    csr_funct3;
  logic [4:0]    csr_imm;
  logic [RW-1:0] rs1_val;
  logic [AW-1:0] csr_addr;
  logic          csr_valid;
  logic          csr_rrsp;
  logic [AW-1:0] csr_rdata;
  logic          csr_rvalid;
  logic [2:0]    csr_reg_rsp;
  logic          wb_valid;
  logic          wb_ready;
  logic [4:0]    wb_rd_idx;
  logic          wb_rd_wen;
  logic [RW-1:0] wb_data;
  logic          wb_excp;
  logic [1:0]    wb_cause;

  typedef struct packed {
    logic [4:0]    rd;
    logic          wen;
    logic [RW-1:0] data;
    logic          excp;
    logic [1:0]    cause;
  } wb_exp_t;

  wb_exp_t sb[$];
  wb_exp_t mon_e;
  wb_exp_t hold_snap;
  logic    hold_prev_valid = 1'b0;
  logic    hold_prev_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int csr_valid_cnt = 0;
  int wait_cnt = 0;

  // Bus responder programming; rsp_lat < 0 means the target never answers.
  int            rsp_lat = -1;
  int            rsp_wait = 0;
  logic          rsp_busy = 1'b0;
  logic [AW-1:0] rsp_data = '0;
  logic [2:0]    rsp_code = '0;

  csr_req_ctrl #(
    .ADDR_WIDTH  (AW),
    .REG_WIDTH   (RW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_rd_idx   (req_rd_idx),
    .req_rs1_idx  (req_rs1_idx),
    .req_rs1_val  (req_rs1_val),
    .req_csr_addr (req_csr_addr),
    .flush        (flush),
    .csr_op       (csr_op),
    .csr_funct3   (csr_funct3),
    .csr_imm      (csr_imm),
    .rs1_val      (rs1_val),
    .csr_addr     (csr_addr),
    .csr_valid    (csr_valid),
    .csr_rrsp     (csr_rrsp),
    .csr_rdata    (csr_rdata),
    .csr_rvalid   (csr_rvalid),
    .csr_reg_rsp  (csr_reg_rsp),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_rd_idx    (wb_rd_idx),
    .wb_rd_wen    (wb_rd_wen),
    .wb_data      (wb_data),
    .wb_excp      (wb_excp),
    .wb_cause     (wb_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Responder: answers rsp_lat cycles after the REQ cycle (0 = same cycle).
  always @(negedge clk) begin
    csr_rvalid = 1'b0;
    if (rst) begin
      rsp_busy = 1'b0;
    end else begin
      if (csr_valid) begin
        rsp_busy = 1'b1;
        rsp_wait = 0;
      end else if (rsp_busy) begin
        rsp_wait++;
      end
      if (rsp_busy && rsp_lat >= 0 && rsp_wait == rsp_lat) begin
        csr_rvalid  = 1'b1;
        csr_rdata   = rsp_data;
        csr_reg_rsp = rsp_code;
        rsp_busy    = 1'b0;
      end
    end
  end

  // Monitor: bus activity counters, stall stability, scoreboard pop at handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (csr_valid) csr_valid_cnt++;
      if (csr_rrsp && !csr_valid) wait_cnt++;
      if (wb_valid && hold_prev_valid && !hold_prev_ready) begin
        check_eq("hold_rd", wb_rd_idx, hold_snap.rd);
        check_eq("hold_wen", wb_rd_wen, hold_snap.wen);
        check_eq("hold_data", wb_data, hold_snap.data);
        check_eq("hold_excp", wb_excp, hold_snap.excp);
        check_eq("hold_cause", wb_cause, hold_snap.cause);
      end
      if (wb_valid && wb_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_unexpected_wb", wb_valid, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("wb_rd_idx", wb_rd_idx, mon_e.rd);
          check_eq("wb_rd_wen", wb_rd_wen, mon_e.wen);
          check_eq("wb_data", wb_data, mon_e.data);
          check_eq("wb_excp", wb_excp, mon_e.excp);
          check_eq("wb_cause", wb_cause, mon_e.cause);
        end
      end
    end
    hold_prev_valid = (wb_valid === 1'b1);
    hold_prev_ready = wb_ready;
    hold_snap       = '{wb_rd_idx, wb_rd_wen, wb_data, wb_excp, wb_cause};
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_rsp(input int lat, input logic [AW-1:0] data, input logic [2:0] code);
    rsp_lat  = lat;
    rsp_data = data;
    rsp_code = code;
    rsp_busy = 1'b0;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic wen, input logic [RW-1:0] data,
                          input logic excp, input logic [1:0] cause);
    sb.push_back('{rd, wen, data, excp, cause});
  endtask

  // Presents one request for a single cycle; returns in the first cycle after acceptance.
  task automatic issue(input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1i,
                       input logic [RW-1:0] rs1v, input logic [AW-1:0] addr);
    check_eq("req_ready_idle", req_ready, 1'b1);
    csr_valid_cnt = 0;
    wait_cnt      = 0;
    req_funct3    = f3;
    req_rd_idx    = rd;
    req_rs1_idx   = rs1i;
    req_rs1_val   = rs1v;
    req_csr_addr  = addr;
    req_valid     = 1'b1;
    step();
    req_valid     = 1'b0;
  endtask

  task automatic wait_wb(input int start, input int max_cyc, output int cyc);
    cyc = start;
    while (!wb_valid && cyc < max_cyc) begin
      step();
      cyc++;
    end
    check_eq("wb_valid_seen", wb_valid, 1'b1);
  endtask

  task automatic complete();
    step();
    check_eq("idle_after_wb", req_ready, 1'b1);
    check_eq("wb_valid_low", wb_valid, 1'b0);
  endtask

  int cyc;
  int seen;

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_funct3   = '0;
    req_rd_idx   = '0;
    req_rs1_idx  = '0;
    req_rs1_val  = '0;
    req_csr_addr = '0;
    flush        = 1'b0;
    wb_ready     = 1'b1;
    csr_rvalid   = 1'b0;
    csr_rdata    = '0;
    csr_reg_rsp  = '0;
    step();
    step();
    check_eq("rst_req_ready", req_ready, 1'b1);
    check_eq("rst_csr_valid", csr_valid, 1'b0);
    check_eq("rst_csr_rrsp", csr_rrsp, 1'b0);
    check_eq("rst_csr_op", csr_op, 2'b00);
    check_eq("rst_wb_valid", wb_valid, 1'b0);
    check_eq("rst_wb_data", wb_data, '0);
    rst = 1'b0;
    step();

    // CSRRS x5, 0x3A0, x0 with a 1-cycle responder.
    set_rsp(1, 32'h0000_001F, 3'b000);
    push_exp(5'd5, 1'b1, 32'h1F, 1'b0, 2'b00);
    issue(3'b010, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h3A0);
    check_eq("t1_csr_valid", csr_valid, 1'b1);
    check_eq("t1_csr_op", csr_op, 2'b10);
    check_eq("t1_csr_addr", csr_addr, 32'h3A0);
    check_eq("t1_csr_rrsp", csr_rrsp, 1'b1);
    step();
    check_eq("t1_wait_valid", csr_valid, 1'b0);
    check_eq("t1_wait_addr", csr_addr, 32'h3A0);
    wait_wb(2, 10, cyc);
    check_eq("t1_latency", cyc, 3);
    check_eq("t1_valid_pulses", csr_valid_cnt, 1);
    check_eq("t1_resp_op_clr", csr_op, 2'b00);
    check_eq("t1_resp_addr_clr", csr_addr, '0);
    complete();

    // CSRRW x0 with a 0-cycle responder.
    set_rsp(0, 32'h0, 3'b000);
    push_exp(5'd0, 1'b0, 32'h0, 1'b0, 2'b00);
    issue(3'b001, 5'd0, 5'd3, 32'h8000_0000, 32'h300);
    check_eq("t2_csr_op", csr_op, 2'b01);
    check_eq("t2_rs1_val", rs1_val, 32'h8000_0000);
    wait_wb(1, 10, cyc);
    check_eq("t2_latency", cyc, 2);
    complete();

    // Illegal funct3: no bus access, exception next cycle.
    set_rsp(0, 32'h1234, 3'b000);
    push_exp(5'd9, 1'b0, 32'h0, 1'b1, 2'b00);
    issue(3'b100, 5'd9, 5'd1, 32'h1, 32'h300);
    wait_wb(1, 10, cyc);
    check_eq("t3_latency", cyc, 1);
    check_eq("t3_no_csr_valid", csr_valid_cnt, 0);
    complete();

    // Silent target at 0x7C0: timeout after TO cycles in WAIT.
    set_rsp(-1, 32'h0, 3'b000);
    push_exp(5'd4, 1'b0, 32'h0, 1'b1, 2'b11);
    issue(3'b011, 5'd4, 5'd2, 32'hF, 32'h7C0);
    wait_wb(1, 60, cyc);
    check_eq("t4_wait_cycles", wait_cnt, TO);
    check_eq("t4_latency", cyc, TO + 2);
    complete();

    // Normal CSRRSI after the timeout, 2-cycle responder.
    set_rsp(2, 32'hCAFE_0001, 3'b000);
    push_exp(5'd12, 1'b1, 32'hCAFE_0001, 1'b0, 2'b00);
    issue(3'b110, 5'd12, 5'd0, 32'h0, 32'h300);
    check_eq("t5_csr_op", csr_op, 2'b10);
    wait_wb(1, 10, cyc);
    check_eq("t5_latency", cyc, 4);
    complete();

    // Target-reported exception, cause 10.
    set_rsp(1, 32'h0000_FFFF, 3'b110);
    push_exp(5'd6, 1'b0, 32'h0, 1'b1, 2'b10);
    issue(3'b010, 5'd6, 5'd0, 32'h0, 32'h305);
    wait_wb(1, 10, cyc);
    complete();

    // CSRRWI: immediate and funct3 presented on the bus.
    set_rsp(0, 32'h0000_00A5, 3'b000);
    push_exp(5'd3, 1'b1, 32'hA5, 1'b0, 2'b00);
    issue(3'b101, 5'd3, 5'd17, 32'h0, 32'h340);
    check_eq("t7_csr_imm", csr_imm, 5'd17);
    check_eq("t7_csr_funct3", csr_funct3, 3'b101);
    check_eq("t7_csr_op", csr_op, 2'b11);
    wait_wb(1, 10, cyc);
    complete();

    // Flush in WAIT: access completes on the bus but no writeback.
    set_rsp(3, 32'h5555, 3'b000);
    issue(3'b010, 5'd8, 5'd0, 32'h0, 32'h341);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (wb_valid) seen++;
      if (req_ready) break;
      step();
    end
    check_eq("t8_no_wb", seen, 0);
    check_eq("t8_back_idle", req_ready, 1'b1);
    check_eq("t8_valid_pulses", csr_valid_cnt, 1);

    // Writeback stall for 5 cycles.
    wb_ready = 1'b0;
    set_rsp(0, 32'h77, 3'b000);
    push_exp(5'd10, 1'b1, 32'h77, 1'b0, 2'b00);
    issue(3'b111, 5'd10, 5'd0, 32'h0, 32'h342);
    wait_wb(1, 10, cyc);
    for (int i = 0; i < 5; i++) begin
      check_eq("t9_stall_valid", wb_valid, 1'b1);
      check_eq("t9_stall_req_ready", req_ready, 1'b0);
      step();
    end
    wb_ready = 1'b1;
    complete();

    // Flush in RESP drops the result.
    wb_ready = 1'b0;
    issue(3'b000, 5'd2, 5'd0, 32'h0, 32'h0);
    wait_wb(1, 10, cyc);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("t10_dropped", wb_valid, 1'b0);
    check_eq("t10_idle", req_ready, 1'b1);
    wb_ready = 1'b1;

    // Flush in IDLE blocks acceptance.
    csr_valid_cnt = 0;
    req_funct3    = 3'b010;
    req_rd_idx    = 5'd1;
    req_csr_addr  = 32'h300;
    req_valid     = 1'b1;
    flush         = 1'b1;
    step();
    req_valid = 1'b0;
    flush     = 1'b0;
    check_eq("t11_no_req", csr_valid, 1'b0);
    check_eq("t11_idle", req_ready, 1'b1);
    step();
    check_eq("t11_no_pulse", csr_valid_cnt, 0);

    // Reset mid-transaction, then a normal access.
    set_rsp(-1, 32'h0, 3'b000);
    issue(3'b010, 5'd1, 5'd0, 32'h0, 32'h343);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t12_idle", req_ready, 1'b1);
    check_eq("t12_rrsp", csr_rrsp, 1'b0);
    check_eq("t12_addr", csr_addr, '0);
    set_rsp(0, 32'h42, 3'b000);
    push_exp(5'd1, 1'b1, 32'h42, 1'b0, 2'b00);
    issue(3'b010, 5'd1, 5'd0, 32'h0, 32'h344);
    wait_wb(1, 10, cyc);
    check_eq("t12_latency", cyc, 2);
    complete();

    step();
    check_eq("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
